// File: rtl/boot_pkg.sv
// Shared types for the instruction boot loader.
//   boot_state_e : loader FSM states
//   BYTE_CNT_W   : width of the byte-within-word counter
//   word_t       : 32-bit instruction/header/checksum word
package boot_pkg;

  localparam int unsigned BYTE_CNT_W = 2;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_LOAD = 3'd1,
    ST_CSUM = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } boot_state_e;

endpackage

// File: rtl/boot_word_packer.sv
// Assembles big-endian 32-bit words from an accepted byte stream.
// Ports:
//   clk_i, rst_i  : clock, async active-high reset (drops any partial word)
//   data_i        : stream byte
//   accept_i      : byte transfer happens on this edge
//   word_valid_c  : combinational, high while the 4th byte of a word is accepted
//   word_c        : combinational, the assembled word (valid with word_valid_c)
module boot_word_packer
  import boot_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       accept_i,
  output logic       word_valid_c,
  output word_t      word_c
);

  logic [23:0]           shift_q;
  logic [BYTE_CNT_W-1:0] cnt_q;

  // First byte of a word ends up in the top byte.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (accept_i) begin
      shift_q <= {shift_q[15:0], data_i};
      cnt_q   <= cnt_q + BYTE_CNT_W'(1);
    end
  end

  assign word_valid_c = accept_i && (cnt_q == BYTE_CNT_W'(3));
  assign word_c       = {shift_q, data_i};

endmodule

// File: rtl/instr_boot_loader.sv
// Loads a program image from a byte-serial valid/ready stream into the
// instruction memory write port and holds the CPU in reset until done.
// Image: 4-byte word count N, N words, optional 4-byte checksum (big-endian).
// Optional feature macro: BOOT_CHECKSUM_EN (checksum word and CSUM state).
// Ports:
//   clk_i, rst_i          : clock, async active-high reset
//   in_data_i/in_valid_i  : stream byte and its valid
//   in_ready_o            : byte accepted on edges with in_valid_i & in_ready_o
//   im_we_o/im_addr_o/im_data_o : one-cycle IM write strobe, byte address, data
//   cpu_rst_o             : CPU reset, released only in DONE
//   done_o / err_o        : image loaded / load aborted
//   words_o               : words written so far
module instr_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned AW        = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [7:0]                     in_data_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  output logic                           im_we_o,
  output logic [AW-1:0]                  im_addr_o,
  output logic [31:0]                    im_data_o,
  output logic                           cpu_rst_o,
  output logic                           done_o,
  output logic                           err_o,
  output logic [$clog2(MEM_WORDS+1)-1:0] words_o
);

  localparam int unsigned WW = $clog2(MEM_WORDS + 1);
  localparam int unsigned IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  boot_state_e   state_q, state_d;
  logic [WW-1:0] n_q, n_d;
  logic [WW-1:0] words_d;
  logic          we_d, ready_d;
  logic [AW-1:0] addr_d;
  word_t         data_d;
  logic          word_valid_c;
  word_t         word_c;
`ifdef BOOT_CHECKSUM_EN
  word_t         sum_q, sum_d;
`endif

  boot_word_packer u_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .data_i       (in_data_i),
    .accept_i     (in_valid_i & in_ready_o),
    .word_valid_c (word_valid_c),
    .word_c       (word_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    words_d = words_o;
    we_d    = 1'b0;
    addr_d  = im_addr_o;
    data_d  = im_data_o;
`ifdef BOOT_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      ST_HDR: begin
`ifdef BOOT_CHECKSUM_EN
        sum_d = '0;
`endif
        if (word_valid_c) begin
          if (word_c > 32'(MEM_WORDS)) begin
            state_d = ST_ERR;
          end else if (word_c == '0) begin
`ifdef BOOT_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_DONE;
`endif
          end else begin
            n_d     = WW'(word_c);
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (word_valid_c) begin
          we_d    = 1'b1;
          addr_d  = AW'({words_o[IW-1:0], 2'b00});
          data_d  = word_c;
          words_d = words_o + WW'(1);
`ifdef BOOT_CHECKSUM_EN
          sum_d   = sum_q + word_c;
          if (words_d == n_q) state_d = ST_CSUM;
`endif
        end
`ifndef BOOT_CHECKSUM_EN
        // One idle cycle after the last strobe so the write commits before release.
        else if (words_o == n_q) begin
          state_d = ST_DONE;
        end
`endif
      end
`ifdef BOOT_CHECKSUM_EN
      ST_CSUM: begin
        if (word_valid_c) state_d = (word_c == sum_q) ? ST_DONE : ST_ERR;
      end
`endif
      default: ;
    endcase

    // Stop accepting once the last word is in, even while LOAD waits to release.
    ready_d = (state_d == ST_HDR) || (state_d == ST_CSUM) ||
              ((state_d == ST_LOAD) && (words_d != n_d));
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_HDR;
      n_q        <= '0;
      words_o    <= '0;
      in_ready_o <= 1'b0;
      im_we_o    <= 1'b0;
      im_addr_o  <= '0;
      im_data_o  <= '0;
      cpu_rst_o  <= 1'b1;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      words_o    <= words_d;
      in_ready_o <= ready_d;
      im_we_o    <= we_d;
      im_addr_o  <= addr_d;
      im_data_o  <= data_d;
      cpu_rst_o  <= (state_d != ST_DONE);
      done_o     <= (state_d == ST_DONE);
      err_o      <= (state_d == ST_ERR);
    end
  end

`ifdef BOOT_CHECKSUM_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sum_q <= '0;
    else       sum_q <= sum_d;
  end
`endif

endmodule

// File: tb/tb_instr_boot_loader.sv
// Scoreboard bench for instr_boot_loader: expected IM writes are queued by the
// stimulus, a negedge monitor pops and compares on every im_we_o strobe.
module tb_instr_boot_loader;

  localparam int unsigned MEM_WORDS = 256;
  localparam int unsigned AW        = 32;
  localparam int unsigned WW        = $clog2(MEM_WORDS + 1);

  logic          clk_i      = 1'b0;
  logic          rst_i      = 1'b0;
  logic [7:0]    in_data_i  = 8'h00;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic          im_we_o;
  logic [AW-1:0] im_addr_o;
  logic [31:0]   im_data_o;
  logic          cpu_rst_o;
  logic          done_o;
  logic          err_o;
  logic [WW-1:0] words_o;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  errors = 0;
  int  checks = 0;

  instr_boot_loader #(.MEM_WORDS(MEM_WORDS), .AW(AW)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_data_i  (in_data_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .im_we_o    (im_we_o),
    .im_addr_o  (im_addr_o),
    .im_data_o  (im_data_o),
    .cpu_rst_o  (cpu_rst_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .words_o    (words_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the expected-write queue.
  always @(negedge clk_i) begin
    if (im_we_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write",
                 im_addr_o, im_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", 32'(im_addr_o), mon_e.addr);
        check("write_data", im_data_o, mon_e.data);
      end
    end
  end

  task automatic expect_write(input logic [31:0] addr, input logic [31:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready_o), 32'd0);
    check({tag, "_im_we"},    32'(im_we_o),    32'd0);
    check({tag, "_im_addr"},  32'(im_addr_o),  32'd0);
    check({tag, "_im_data"},  im_data_o,       32'd0);
    check({tag, "_cpu_rst"},  32'(cpu_rst_o),  32'd1);
    check({tag, "_done"},     32'(done_o),     32'd0);
    check({tag, "_err"},      32'(err_o),      32'd0);
    check({tag, "_words"},    32'(words_o),    32'd0);
  endtask

  // Called at posedge+1; reset outputs are checked asynchronously, 1 ns after assertion.
  task automatic do_reset(input string tag);
    rst_i      = 1'b1;
    in_valid_i = 1'b0;
    #1;
    check_reset_vals(tag);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  // Offers one byte until accepted (bounded); returns at posedge+1 of the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    bit got;
    got        = 1'b0;
    in_data_i  = b;
    in_valid_i = 1'b1;
    for (int t = 0; t < 20 && !got; t++) begin
      got = in_ready_o;
      @(posedge clk_i);
      #1;
    end
    in_valid_i = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL byte_accept: got in_ready_o=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int unsigned max_gap);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, max_gap)) @(posedge clk_i);
      #0;
      send_byte(w[31-8*i -: 8]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    do_reset("por");
    @(posedge clk_i);
    #1;
    check("por_ready_rises", 32'(in_ready_o), 32'd1);

    // N=2 image, words 0x20080005 / 0x2009000A.
    send_word(32'd2, 0);
    expect_write(32'h0, 32'h20080005);
    send_word(32'h20080005, 0);
    expect_write(32'h4, 32'h2009000A);
    send_word(32'h2009000A, 0);
`ifdef BOOT_CHECKSUM_EN
    check("a_csum_ready", 32'(in_ready_o), 32'd1);
    check("a_csum_cpu_rst", 32'(cpu_rst_o), 32'd1);
    send_word(32'h4011000F, 0);
    check("a_done", 32'(done_o), 32'd1);
    check("a_cpu_rst", 32'(cpu_rst_o), 32'd0);
`else
    check("a_last_we", 32'(im_we_o), 32'd1);
    check("a_last_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check("a_last_done", 32'(done_o), 32'd0);
    check("a_last_ready", 32'(in_ready_o), 32'd0);
    @(posedge clk_i);
    #1;
    check("a_cpu_rst", 32'(cpu_rst_o), 32'd0);
    check("a_done", 32'(done_o), 32'd1);
`endif
    check("a_err", 32'(err_o), 32'd0);
    check("a_words", 32'(words_o), 32'd2);
    // Bytes offered in DONE are never consumed.
    in_data_i  = 8'hFF;
    in_valid_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    check("done_ready", 32'(in_ready_o), 32'd0);
    check("done_hold", 32'(done_o), 32'd1);
    check("done_words", 32'(words_o), 32'd2);

`ifdef BOOT_CHECKSUM_EN
    // Same image, wrong checksum.
    do_reset("bad");
    send_word(32'd2, 0);
    expect_write(32'h0, 32'h20080005);
    send_word(32'h20080005, 0);
    expect_write(32'h4, 32'h2009000A);
    send_word(32'h2009000A, 0);
    send_word(32'h4011000E, 0);
    check("bad_err", 32'(err_o), 32'd1);
    check("bad_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check("bad_ready", 32'(in_ready_o), 32'd0);
    check("bad_done", 32'(done_o), 32'd0);
`endif

    // Oversize header: N = MEM_WORDS+1.
    do_reset("ovf");
    send_word(32'd257, 0);
    check("ovf_err", 32'(err_o), 32'd1);
    check("ovf_ready", 32'(in_ready_o), 32'd0);
    check("ovf_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check("ovf_done", 32'(done_o), 32'd0);
    repeat (3) @(posedge clk_i);
    #1;
    check("ovf_err_hold", 32'(err_o), 32'd1);
    check("ovf_words", 32'(words_o), 32'd0);

    // Empty image: N = 0.
    do_reset("zero");
    send_word(32'd0, 0);
`ifdef BOOT_CHECKSUM_EN
    check("zero_csum_ready", 32'(in_ready_o), 32'd1);
    send_word(32'd0, 0);
`endif
    check("zero_done", 32'(done_o), 32'd1);
    check("zero_cpu_rst", 32'(cpu_rst_o), 32'd0);
    check("zero_words", 32'(words_o), 32'd0);

    // N=3 with random valid gaps.
    do_reset("gap");
    send_word(32'd3, 3);
    expect_write(32'h0, 32'h11223344);
    send_word(32'h11223344, 3);
    expect_write(32'h4, 32'hDEADBEEF);
    send_word(32'hDEADBEEF, 3);
    expect_write(32'h8, 32'h00000001);
    send_word(32'h00000001, 3);
`ifdef BOOT_CHECKSUM_EN
    send_word(32'hEFCFF234, 3);
`endif
    repeat (2) @(posedge clk_i);
    #1;
    check("gap_done", 32'(done_o), 32'd1);
    check("gap_words", 32'(words_o), 32'd3);

    // Reset after 6 bytes, then reload a single-word image.
    do_reset("pre_mid");
    send_word(32'd2, 0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    do_reset("mid");
    send_word(32'd1, 0);
    expect_write(32'h0, 32'hCAFEF00D);
    send_word(32'hCAFEF00D, 0);
`ifdef BOOT_CHECKSUM_EN
    send_word(32'hCAFEF00D, 0);
`endif
    repeat (2) @(posedge clk_i);
    #1;
    check("reload_done", 32'(done_o), 32'd1);
    check("reload_cpu_rst", 32'(cpu_rst_o), 32'd0);
    check("reload_words", 32'(words_o), 32'd1);

    repeat (2) @(posedge clk_i);
    #1;
    check("writes_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_boot_loader.md
# instr_boot_loader

Loads a program image from a byte-serial valid/ready stream into the instruction memory's write port, holding the single-cycle CPU in reset until the load completes. Sits upstream of the CPU. It owns the IM write port and the CPU reset line, so the CPU never fetches a partially written image. The CPU's `rst_i` is driven by this block's `cpu_rst_o`.

## Interface
Parameters:
- `MEM_WORDS`, 256: instruction memory depth in 32-bit words; largest accepted image.
- `AW`, 32: width of `im_addr_o` (byte address).

Ports:
- `clk_i` in 1: system clock; all state updates on its rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `in_data_i` in 8: stream byte.
- `in_valid_i` in 1: `in_data_i` is valid.
- `in_ready_o` out 1: block accepts a byte; transfer occurs on an edge where `in_valid_i & in_ready_o`.
- `im_we_o` out 1: one-cycle IM write strobe.
- `im_addr_o` out AW: IM byte address; word-aligned (bits [1:0]=0).
- `im_data_o` out 32: IM write data.
- `cpu_rst_o` out 1: CPU reset, active-high.
- `done_o` out 1: image loaded and verified; CPU released.
- `err_o` out 1: load aborted; CPU stays in reset.
- `words_o` out clog2(MEM_WORDS+1): words written so far.

## Operation
- Image format, big-endian byte order throughout:
  - 4-byte word count N.
  - N instruction words.
  - With `BOOT_CHECKSUM_EN` only: one 4-byte checksum word.
- States:
  - HDR: collect 4 bytes into N.
    - N > MEM_WORDS → ERR.
    - N = 0 → CSUM if the checksum is enabled, else DONE.
    - Otherwise → LOAD.
  - LOAD: collect 4 bytes per word. Each completed word is written to byte address 4·i, with i counting from 0.
    - After word N−1 is written → CSUM if enabled, else DONE.
  - CSUM: collect 4 bytes.
    - Match → DONE.
    - Mismatch → ERR.
  - DONE and ERR: terminal. Only `rst_i` leaves them.
- `in_ready_o` is 1 in HDR, LOAD and CSUM, and 0 in DONE and ERR. Bytes offered in DONE or ERR are never consumed.
- `cpu_rst_o` is 1 in every state except DONE.
- Address arithmetic: the word index is held as clog2(MEM_WORDS) bits, and `im_addr_o` = index<<2, zero-extended to AW. The index never wraps, because N ≤ MEM_WORDS is enforced in HDR.
- A stalled stream (`in_valid_i` = 0) holds all state and the partial byte count indefinitely. There is no timeout.

## Timing
- Reset values (asynchronous):
  - state = HDR.
  - `in_ready_o` = 0; it rises on the first edge after `rst_i` falls.
  - `im_we_o` = 0, `im_addr_o` = 0, `im_data_o` = 0.
  - `cpu_rst_o` = 1, `done_o` = 0, `err_o` = 0, `words_o` = 0.
- All outputs are registered.
- Write latency: the edge that accepts the 4th byte of word i registers `im_we_o` = 1 with that word's address and data. The strobe is held exactly one cycle, and `words_o` increments on the same edge.
  - Back-to-back bytes cannot overlap strobes, because a word needs at least 4 accepting edges.
- Release: the edge that enters DONE registers `cpu_rst_o` = 0 and `done_o` = 1.
  - That edge is at least one cycle after the last `im_we_o` edge, so the final IM write commits before the CPU's first fetch.
- The edge that enters ERR registers `err_o` = 1 and `in_ready_o` = 0.
- `rst_i` asserted mid-load:
  - Everything returns to the reset values immediately.
  - The partial word is discarded and no strobe is issued.
  - IM contents already written are left untouched.

## Configuration
- `BOOT_CHECKSUM_EN` defined:
  - A running 32-bit sum of the instruction words is kept, wrapping mod 2^32 and cleared in HDR.
  - The CSUM state is present.
  - On mismatch the block enters ERR.
- `BOOT_CHECKSUM_EN` undefined:
  - No adder and no CSUM state.
  - LOAD goes directly to DONE after the last word.
  - `err_o` can only be raised by N > MEM_WORDS.

## Structure
- Package `boot_pkg` holds:
  - the state enum (HDR, LOAD, CSUM, DONE, ERR);
  - the byte-count width constant;
  - the 32-bit word type.
- Sub-module `boot_word_packer`:
  - Shifts in bytes under the handshake and has a 2-bit byte counter.
  - Pulses `word_valid` with the assembled word on the 4th byte.
  - The FSM consumes its output for HDR, LOAD and CSUM alike.

## Test plan
- Stream N=2, words 0x20080005 and 0x2009000A, checksum undefined:
  - `im_we_o` pulses at address 0x0 then 0x4 with those words.
  - `cpu_rst_o` falls one cycle after the 2nd strobe, and `done_o` = 1.
- Same image with `BOOT_CHECKSUM_EN` and checksum 0x4011000F:
  - DONE is reached.
  - With checksum 0x4011000E instead: `err_o` = 1, `cpu_rst_o` stays 1, `in_ready_o` = 0.
- Header N = MEM_WORDS+1:
  - ERR right after the 4th header byte.
  - No `im_we_o` pulse.
- Header N=0:
  - DONE after the header (or after the checksum 0x00000000 when enabled).
  - No write strobe.
- Random `in_valid_i` gaps, N=3:
  - Identical addresses and data to the gap-free run.
  - `words_o` ends at 3.
- `rst_i` pulse after 6 bytes:
  - All outputs return to reset values.
  - Reloading a full N=1 image writes address 0x0 and releases the CPU.
